lsu_axil: RTL

- Parametrised load/store unit bridging the core's memory stage to an AXI4-Lite master port.
- Accepts one load or store request at a time.
- Generates address-aligned byte-lane strobes and performs lane shifting plus sign/zero extension on loads.
- Reports bus errors and misaligned accesses back to the core.
- Supports 32- or 64-bit data paths.

---
 rtl/lsu_axil.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_axil.sv
// Load/store unit: one core memory request at a time onto an AXI4-Lite master, with lane steering and load extension.
// Optional watchdog LSU_TIMEOUT_EN aborts a hung transaction after TIMEOUT_CYCLES with resp_err.
module lsu_axil #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_sext,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                resp_misalign,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int SW   = DATA_W / 8;
  localparam int OFFW = $clog2(SW);

  if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("lsu_axil: DATA_W must be 32 or 64 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t              state_q, state_d;
  logic [OFFW-1:0]     off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic                resp_misalign_q, resp_misalign_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;

  logic                accept, req_misalign;
  logic [OFFW-1:0]     req_off;
  logic [3:0]          req_nbytes;
  logic [ADDR_W-1:0]   req_aligned;
  logic [SW-1:0]       strb_base;
  logic [DATA_W-1:0]   ld_shift, ld_mask, ld_ext;
  logic                ld_sign;

  assign req_ready   = (state_q == IDLE);
  assign accept      = req_valid && req_ready;
  assign req_off     = req_addr[OFFW-1:0];
  assign req_nbytes  = 4'd1 << req_size;
  // A dword on a 32-bit bus cannot be expressed by the strobes, so it is rejected like a misaligned access.
  assign req_misalign = ((req_off & OFFW'(req_nbytes - 4'd1)) != '0) ||
                        (DATA_W == 32 && req_size == 2'd3);
  assign req_aligned = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign strb_base   = ~({SW{1'b1}} << req_nbytes);

  // Shifts past the bus width yield zero, so full-width accesses get an all-ones mask.
  assign ld_shift = rdata >> {off_q, 3'b000};
  assign ld_mask  = ~({DATA_W{1'b1}} << (7'd8 << size_q));
  always_comb begin
    case (size_q)
      2'd0:    ld_sign = ld_shift[7];
      2'd1:    ld_sign = ld_shift[15];
      2'd2:    ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[DATA_W-1];
    endcase
  end
  assign ld_ext = (ld_shift & ld_mask) | ((sext_q && ld_sign) ? ~ld_mask : '0);

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    size_d          = size_q;
    sext_d          = sext_q;
    arvalid_d       = arvalid_q;
    rready_d        = rready_q;
    awvalid_d       = awvalid_q;
    wvalid_d        = wvalid_q;
    bready_d        = bready_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    araddr_d        = araddr_q;
    awaddr_d        = awaddr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    resp_valid_d    = 1'b0;
    resp_err_d      = 1'b0;
    resp_misalign_d = 1'b0;
    resp_rdata_d    = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_misalign) begin
            resp_valid_d    = 1'b1;
            resp_misalign_d = 1'b1;
          end else begin
            off_d  = req_off;
            size_d = req_size;
            sext_d = req_sext;
            if (req_wen) begin
              state_d   = WR_REQ;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              aw_done_d = 1'b0;
              w_done_d  = 1'b0;
              awaddr_d  = req_aligned;
              wdata_d   = req_wdata << {req_off, 3'b000};
              wstrb_d   = strb_base << req_off;
            end else begin
              state_d   = RD_ADDR;
              arvalid_d = 1'b1;
              araddr_d  = req_aligned;
            end
          end
        end
      end
      RD_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid && rready_q) begin
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (rresp != 2'b00);
          resp_rdata_d = (rresp != 2'b00) ? '0 : ld_ext;
          state_d      = IDLE;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q || (awvalid_q && awready);
        w_done_d  = w_done_q || (wvalid_q && wready);
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid && bready_q) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (bresp != 2'b00);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef LSU_TIMEOUT_EN
    if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d         = IDLE;
      arvalid_d       = 1'b0;
      rready_d        = 1'b0;
      awvalid_d       = 1'b0;
      wvalid_d        = 1'b0;
      bready_d        = 1'b0;
      resp_valid_d    = 1'b1;
      resp_err_d      = 1'b1;
      resp_misalign_d = 1'b0;
      resp_rdata_d    = '0;
    end
    tmo_d = (state_d != state_q || state_q == IDLE) ? '0 : tmo_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      off_q           <= '0;
      size_q          <= '0;
      sext_q          <= 1'b0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      bready_q        <= 1'b0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      araddr_q        <= '0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_misalign_q <= 1'b0;
      resp_rdata_q    <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      off_q           <= off_d;
      size_q          <= size_d;
      sext_q          <= sext_d;
      arvalid_q       <= arvalid_d;
      rready_q        <= rready_d;
      awvalid_q       <= awvalid_d;
      wvalid_q        <= wvalid_d;
      bready_q        <= bready_d;
      aw_done_q       <= aw_done_d;
      w_done_q        <= w_done_d;
      araddr_q        <= araddr_d;
      awaddr_q        <= awaddr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_misalign_q <= resp_misalign_d;
      resp_rdata_q    <= resp_rdata_d;
`ifdef LSU_TIMEOUT_EN
      tmo_q           <= tmo_d;
`endif
    end
  end

  assign araddr        = araddr_q;
  assign arvalid       = arvalid_q;
  assign rready        = rready_q;
  assign awaddr        = awaddr_q;
  assign awvalid       = awvalid_q;
  assign wdata         = wdata_q;
  assign wstrb         = wstrb_q;
  assign wvalid        = wvalid_q;
  assign bready        = bready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_misalign = resp_misalign_q;
  assign resp_rdata    = resp_rdata_q;

endmodule
